// File: rtl/konami_line_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module   : konami_line_buffer_writer
//  Purpose  : Ping-pong sprite line-buffer pair that feeds the DA/DB nibble
//             buses of the colour-code mux.
//             - The draw bank accepts priority-masked pixel writes from the
//               sprite engine. The first opaque pixel at a location wins.
//             - The display bank is read out one pixel per pix_en. Each
//               location is cleared as it is read.
//  Ports    : clk, reset         clock and synchronous active-high reset
//             line_start         swap banks, restart readout at address 0
//             pix_en             read and clear one display location
//             wr_valid/wr_ready  write handshake (wr_x address, wr_cc colour)
//             da_o, db_o         bank A / bank B readout (0 when drawing)
//             ldout_o            1 = bank A on screen, 0 = bank B on screen
//             busy_o             high during the post-reset clear sweep
//  Revision : 1.0  initial release
// ============================================================================
module konami_line_buffer_writer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic              pix_en,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_x,
  input  logic [3:0]        wr_cc,
  output logic              wr_ready,
  output logic [3:0]        da_o,
  output logic [3:0]        db_o,
  output logic              ldout_o,
  output logic              busy_o
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RD    = 2'd2,
    ST_WR    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_x_q, wr_x_d;
  logic [3:0]        wr_cc_q, wr_cc_d;
  logic [3:0]        old_q, old_d;
  logic [3:0]        da_q, da_d;
  logic [3:0]        db_q, db_d;
  logic              ldout_q, ldout_d;
  logic              busy_q, busy_d;

  logic [3:0] mem_a_q [DEPTH];
  logic [3:0] mem_b_q [DEPTH];

  // One write port per bank; display-clear and draw-write never hit the same bank.
  logic              we_a, we_b;
  logic [ADDR_W-1:0] wa_a, wa_b;
  logic [3:0]        wd_a, wd_b;

  logic       w_ls_go;
  logic       w_rd_go;
  logic [3:0] w_draw_rd;

  // line_start and pix_en have no effect while the clear sweep runs.
  assign w_ls_go   = line_start && (state_q != ST_CLEAR);
  assign w_rd_go   = pix_en && !line_start && (state_q != ST_CLEAR);
  // ldout_q=1 means A is on screen, so B is the draw bank.
  assign w_draw_rd = ldout_q ? mem_b_q[wr_x_q] : mem_a_q[wr_x_q];

  assign wr_ready = (state_q == ST_IDLE) && !line_start;
  assign da_o     = da_q;
  assign db_o     = db_q;
  assign ldout_o  = ldout_q;
  assign busy_o   = busy_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_x_d     = wr_x_q;
    wr_cc_d    = wr_cc_q;
    old_d      = old_q;
    da_d       = da_q;
    db_d       = db_q;
    ldout_d    = ldout_q;
    busy_d     = busy_q;
    we_a       = 1'b0;
    wa_a       = '0;
    wd_a       = 4'h0;
    we_b       = 1'b0;
    wa_b       = '0;
    wd_b       = 4'h0;

    case (state_q)
      ST_CLEAR: begin
        we_a       = 1'b1;
        wa_a       = clr_addr_q;
        we_b       = 1'b1;
        wa_b       = clr_addr_q;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        if (wr_valid && wr_ready) begin
          wr_x_d  = wr_x;
          wr_cc_d = wr_cc;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (line_start) begin
          state_d = ST_IDLE;
        end else begin
          old_d   = w_draw_rd;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
        // Transparent pixels never write; an occupied location keeps its first owner.
        if (!line_start && (wr_cc_q != 4'h0) && (old_q == 4'h0)) begin
          if (ldout_q) begin
            we_b = 1'b1;
            wa_b = wr_x_q;
            wd_b = wr_cc_q;
          end else begin
            we_a = 1'b1;
            wa_a = wr_x_q;
            wd_a = wr_cc_q;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    if (w_ls_go) begin
      ldout_d   = !ldout_q;
      rd_addr_d = '0;
      da_d      = 4'h0;
      db_d      = 4'h0;
    end else if (w_rd_go) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
      if (ldout_q) begin
        da_d = mem_a_q[rd_addr_q];
        db_d = 4'h0;
        we_a = 1'b1;
        wa_a = rd_addr_q;
        wd_a = 4'h0;
      end else begin
        da_d = 4'h0;
        db_d = mem_b_q[rd_addr_q];
        we_b = 1'b1;
        wa_b = rd_addr_q;
        wd_b = 4'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      rd_addr_q  <= '0;
      wr_x_q     <= '0;
      wr_cc_q    <= 4'h0;
      old_q      <= 4'h0;
      da_q       <= 4'h0;
      db_q       <= 4'h0;
      ldout_q    <= 1'b1;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_x_q     <= wr_x_d;
      wr_cc_q    <= wr_cc_d;
      old_q      <= old_d;
      da_q       <= da_d;
      db_q       <= db_d;
      ldout_q    <= ldout_d;
      busy_q     <= busy_d;
    end
  end

  // Bank storage has no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (we_a) mem_a_q[wa_a] <= wd_a;
    if (we_b) mem_b_q[wa_b] <= wd_b;
  end

endmodule
`default_nettype wire

// File: tb/tb_konami_line_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_konami_line_buffer_writer
//  Purpose  : Scoreboard bench for konami_line_buffer_writer. The driver
//             updates a per-cycle reference model of both banks and queues the
//             expected outputs; a negedge monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_konami_line_buffer_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line_start = 1'b0;
  logic       pix_en = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_x = 8'h00;
  logic [3:0] wr_cc = 4'h0;
  logic       wr_ready;
  logic [3:0] da_o, db_o;
  logic       ldout_o, busy_o;

  konami_line_buffer_writer #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .line_start(line_start),
    .pix_en    (pix_en),
    .wr_valid  (wr_valid),
    .wr_x      (wr_x),
    .wr_cc     (wr_cc),
    .wr_ready  (wr_ready),
    .da_o      (da_o),
    .db_o      (db_o),
    .ldout_o   (ldout_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         due;
    logic [3:0] da;
    logic [3:0] db;
    logic       ld;
    logic       busy;
  } exp_t;
  exp_t sb[$];

  // Reference model: contents of each bank plus what the screen side shows.
  logic [3:0] m_a [256];
  logic [3:0] m_b [256];
  int         m_clr_left = 0;
  logic       m_ld = 1'b1;
  int         m_rd = 0;
  logic [3:0] m_da = 4'h0, m_db = 4'h0;
  int         m_pend = 0;      // cycles until the accepted pixel lands
  int         m_px = 0;
  logic [3:0] m_pcc = 4'h0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("da_o",    da_o, e.da);
      check("db_o",    db_o, e.db);
      check("ldout_o", 4'(ldout_o), 4'(e.ld));
      check("busy_o",  4'(busy_o),  4'(e.busy));
    end
  end

  // One clock of stimulus; the model applies the same cycle's effects.
  task automatic step(input bit pix, input bit ls, input bit wv,
                      input logic [7:0] x, input logic [3:0] cc, input bit rst);
    exp_t e;
    logic [3:0] v;
    reset = rst; line_start = ls; pix_en = pix; wr_valid = wv; wr_x = x; wr_cc = cc;
    #1;
    if (!rst) check("wr_ready", 4'(wr_ready), 4'((m_clr_left == 0) && (m_pend == 0) && !ls));
    if (rst) begin
      for (int i = 0; i < 256; i++) begin m_a[i] = 4'h0; m_b[i] = 4'h0; end
      m_clr_left = 256; m_ld = 1'b1; m_rd = 0; m_da = 4'h0; m_db = 4'h0; m_pend = 0;
    end else if (m_clr_left > 0) begin
      m_clr_left--;
    end else begin
      if (m_pend > 0) begin
        if (ls) m_pend = 0;
        else begin
          m_pend--;
          if (m_pend == 0 && m_pcc != 4'h0) begin
            if (m_ld) begin if (m_b[m_px] == 4'h0) m_b[m_px] = m_pcc; end
            else      begin if (m_a[m_px] == 4'h0) m_a[m_px] = m_pcc; end
          end
        end
      end else if (wv && !ls) begin
        m_pend = 2; m_px = int'(x); m_pcc = cc;
      end
      if (ls) begin
        m_ld = !m_ld; m_rd = 0; m_da = 4'h0; m_db = 4'h0;
      end else if (pix) begin
        if (m_ld) begin v = m_a[m_rd]; m_a[m_rd] = 4'h0; m_da = v; m_db = 4'h0; end
        else      begin v = m_b[m_rd]; m_b[m_rd] = 4'h0; m_da = 4'h0; m_db = v; end
        m_rd = (m_rd + 1) % 256;
      end
    end
    e.due = cyc + 1; e.da = m_da; e.db = m_db; e.ld = m_ld; e.busy = (m_clr_left > 0);
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 4'h0, 0);
  endtask

  task automatic pix(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 8'h00, 4'h0, 0);
  endtask

  task automatic lstart();
    step(0, 1, 0, 8'h00, 4'h0, 0);
  endtask

  task automatic wr(input logic [7:0] x, input logic [3:0] cc);
    step(0, 0, 1, x, cc, 0);
    idle(2);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    // Reset, clear sweep, then a full line of readout from each bank.
    step(0, 0, 0, 8'h00, 4'h0, 1);
    idle(256);
    pix(256); lstart(); pix(256);
    // Single opaque pixel into B, shown on the 6th read; replay shows it cleared.
    lstart();
    wr(8'd5, 4'h7);
    lstart(); pix(6);
    lstart(); lstart(); pix(6);
    // First opaque pixel wins; transparent never writes.
    lstart();
    wr(8'd9, 4'h3); wr(8'd9, 4'hC); wr(8'd9, 4'h0);
    lstart(); pix(12);
    // Write aborted by line_start in its RD cycle, and in its WR cycle.
    step(0, 0, 1, 8'd20, 4'h5, 0);
    step(0, 1, 1, 8'd20, 4'h5, 0);
    step(0, 0, 1, 8'd21, 4'h6, 0);
    step(0, 0, 0, 8'h00, 4'h0, 0);
    step(0, 1, 1, 8'd21, 4'h6, 0);
    step(0, 1, 1, 8'd22, 4'h8, 0);   // line_start while idle blocks acceptance
    idle(2); lstart(); pix(24);
    // Readout wrap: 257 reads after line_start.
    lstart();
    wr(8'd0, 4'h4); wr(8'd255, 4'h2);
    lstart(); pix(257);
    // line_start with pix_en: swap only, nothing cleared.
    lstart();
    wr(8'd0, 4'h6);
    lstart();
    step(1, 1, 0, 8'h00, 4'h0, 0);
    lstart(); pix(2);
    // Randomised traffic, a mid-run reset, then more traffic.
    rand_steps(2500);
    step(1, 0, 1, 8'd3, 4'h9, 1);
    rand_steps(300);
    pix(8);
    rand_steps(1200);
    idle(2);
    @(negedge clk); #1;
    check("scoreboard_drained", 4'(sb.size() != 0), 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
